// File: rtl/hamming_slicer.sv
// hamming_slicer: feeds N-bit operand pairs to the multi-cycle hamming unit as CC slices of M bits
// and returns the captured distance.
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : operand pair handshake carrying x_in, y_in
//   x/y_slice       : LSB-first slices toward hamming.x / hamming.y, zero outside SHIFT
//   slice_valid/last: slice qualifiers; slice_last marks the final slice of a pair
//   acc_clr         : one-cycle clear for the unit accumulator, ORed with rst by the integrator
//   dist_in         : running distance from hamming.o
//   dist_out/valid/ready: result handshake
module hamming_slicer #(
    parameter int N = 8,
    parameter int CC = 1,
    localparam int M = N / CC,
    localparam int W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    output logic [M-1:0] x_slice,
    output logic [M-1:0] y_slice,
    output logic         slice_valid,
    output logic         slice_last,
    output logic         acc_clr,
    input  logic [W-1:0] dist_in,
    output logic [W-1:0] dist_out,
    output logic         dist_valid,
    input  logic         dist_ready
);
    localparam int CW = CC > 1 ? $clog2(CC) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    if (CC < 1 || N % CC != 0) begin : g_param_check
        $error("hamming_slicer: CC must be >= 1 and divide N");
    end

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [W-1:0]  dist_q, dist_d;

    assign in_ready    = state_q == IDLE;
    assign acc_clr     = state_q == CLEAR;
    assign slice_valid = state_q == SHIFT;
    assign dist_valid  = state_q == DONE;
    assign slice_last  = slice_valid && cnt_q == CW'(CC - 1);
    assign x_slice     = slice_valid ? sx_q[M-1:0] : '0;
    assign y_slice     = slice_valid ? sy_q[M-1:0] : '0;
    assign dist_out    = dist_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        dist_d  = dist_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sx_d    = x_in;
                sy_d    = y_in;
                state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                sx_d  = sx_q >> M;
                sy_d  = sy_q >> M;
                // wrap to 0 on the last slice so cnt never passes CC-1
                cnt_d = slice_last ? '0 : cnt_q + 1'b1;
                if (slice_last) begin
                    dist_d  = dist_in;
                    state_d = DONE;
                end
            end
            default: if (dist_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            dist_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            dist_q  <= dist_d;
        end
    end
endmodule

// File: doc/hamming_slicer.md
# hamming_slicer

Operand sequencer that drives the multi-cycle `hamming` distance unit from the producer side. It accepts full N-bit operand pairs through a valid/ready handshake and serializes them into M = N/CC-bit slices, LSB slice first, one per clock. It controls the unit's accumulator clear, captures the unit's final distance and returns it through a second valid/ready handshake. It sits between the operand source and `hamming`, whose `x`, `y`, `rst` and `o` it drives or samples.

## Interface
- `N`, default 8: full operand width in bits.
- `CC`, default 1: slices per operand (clock cycles per distance). N % CC == 0 and CC >= 1 are required; violating either is an elaboration error.
- Derived: M = N/CC (slice width); W = floor(log2 N)+1 (distance width, equal to the unit's `o` width).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  slicer can accept a pair.
- `x_in`  in  N  operand X.
- `y_in`  in  N  operand Y.
- `x_slice`  out  M  to `hamming.x`.
- `y_slice`  out  M  to `hamming.y`.
- `slice_valid`  out  1  slice outputs carry operand data this cycle.
- `slice_last`  out  1  final slice of the current pair.
- `acc_clr`  out  1  registered one-cycle clear pulse for the unit's accumulator. The integrator ORs it with `rst` onto `hamming.rst`.
- `dist_in`  in  W  from `hamming.o`.
- `dist_out`  out  W  captured Hamming distance.
- `dist_valid`  out  1  `dist_out` holds a result.
- `dist_ready`  in  1  consumer takes the result.

## Operation
- FSM has four states: IDLE, CLEAR, SHIFT, DONE. The reset state is IDLE.
- **IDLE**
  - `in_ready`=1. All slice outputs are 0.
  - On `in_valid`&&`in_ready`: latch `x_in`/`y_in` into shift registers sx/sy and go to CLEAR.
- **CLEAR** (exactly 1 cycle)
  - `acc_clr`=1. `x_slice`=`y_slice`=0 and `slice_valid`=0.
  - Set cnt=0 and go to SHIFT.
- **SHIFT** (exactly CC cycles)
  - `x_slice`=sx[M-1:0], `y_slice`=sy[M-1:0], `slice_valid`=1.
  - Each cycle: sx/sy shift right by M, cnt increments.
  - `slice_last`=1 when cnt==CC-1. On that edge, capture `dist_in` into `dist_out` and go to DONE.
- **DONE**
  - `dist_valid`=1; `dist_out` is held stable. Slice outputs are 0.
  - On `dist_ready`: go to IDLE.
- **Idle zeros.** In every non-SHIFT state, `x_slice` and `y_slice` are 0. The unit therefore accumulates 0 if it is clocked outside SHIFT.
- **cnt width.** cnt is max(1, ceil(log2 CC)) bits. It never exceeds CC-1.
- **CC=1.** SHIFT lasts one cycle, and the slice is the full operand. `dist_in` is the combinational popcount and is captured on that edge. The CLEAR pulse is still issued; it is harmless.
- **Distance range.** The result range is 0..N and fits in W bits; no saturation is needed.
- **Reset.** `rst` asserted at any time, including mid-SHIFT or in DONE, forces IDLE immediately. The partial result is discarded and all registers are cleared.
- **Backpressure.** `in_valid` asserted outside IDLE is ignored, and the pair is not consumed. `dist_ready` asserted outside DONE is ignored.

## Timing
- **Reset values:** `in_ready`=1 (IDLE), `x_slice`=0, `y_slice`=0, `slice_valid`=0, `slice_last`=0, `acc_clr`=0, `dist_out`=0, `dist_valid`=0.
- **Outputs.** All outputs are decoded from registered state only; there is no combinational input-to-output path.
- **Latency.** From the accept edge (cycle 0):
  - `acc_clr` is high in cycle 1.
  - Slices are presented in cycles 2..CC+1.
  - `dist_valid` rises in cycle CC+2.
- **Throughput.** Minimum initiation interval is CC+3 cycles, reached with `dist_ready` held high and `in_valid` reasserted in the returning IDLE cycle.
- **Handshakes.**
  - Transfer occurs on a rising edge with valid&&ready both high.
  - `dist_valid` stays high and `dist_out` stays unchanged until the transfer.

## Test plan
- **CC=1, N=8.** Stimulus: x_in=8'hFF, y_in=8'h00. Required: one SHIFT cycle with `slice_last`=1; `dist_out`=8 with `dist_valid` in cycle 3. Repeat with x_in=y_in=8'h3C → `dist_out`=0.
- **CC=4, N=8 (M=2).** Stimulus: x_in=8'hA5, y_in=8'h5A. Required:
  - `x_slice` sequence 01,01,10,10 and `y_slice` sequence 10,10,01,01.
  - `slice_last` only on the 4th slice.
  - `acc_clr` pulses once, exactly one cycle before the first slice.
  - `dist_out`=8.
- **Backpressure, CC=4.** Stimulus: x=8'h0F, y=8'h0E, with `dist_ready` held low for 5 cycles after `dist_valid`. Required:
  - `dist_out`=1, held stable.
  - `in_ready`=0 throughout, and a new `in_valid` is not consumed.
  - Return to IDLE one cycle after `dist_ready` rises.
- **Back-to-back, CC=4.** Stimulus: pairs (8'hFF, 8'h00) then (8'h01, 8'h00), with `in_valid` and `dist_ready` held high. Required: results 8 then 1, showing no carry-over from the first accumulation; initiation interval = 7 cycles.
- **Reset mid-SHIFT, CC=4.** Stimulus: assert `rst` during the 2nd slice. Required:
  - All outputs go to their reset values immediately and no `dist_valid` appears.
  - A following pair (8'hF0, 8'h0F) yields 8.
